xy_port_allocator: RTL
======================

Name: xy_port_allocator

Overview:
- Round-robin, packet-locking allocator for one output port of the 5-port mesh router (local, east, west, north, south).
- Selects one input requester, holds the grant for the whole multi-flit packet (head to tail), and drives one registered flit per cycle to the output link.
- Tracks downstream buffer credits so that no flit is sent without a free slot.
- One instance per router output port; `flit_out` feeds the inter-router link register stage.

Parameters:
- NREQ, 5, number of input requesters (index 0=local, 1=east, 2=west, 3=north, 4=south).
- DATAWID, 32, flit width in bits.
- HEAD_BIT, 31, flit bit marking a head flit.
- TAIL_BIT, 30, flit bit marking a tail flit (head+tail both set = single-flit packet).
- CREDITS, 4, downstream buffer depth; CW = $clog2(CREDITS+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  requester i has a valid flit on its slice of flit_in.
- flit_in  in  NREQ*DATAWID  requester i flit at bits [i*DATAWID +: DATAWID].
- ready  out  NREQ  combinational; flit i is accepted this cycle when req[i] & ready[i]. At most one bit set.
- credit_ret  in  1  downstream freed one buffer slot (1-cycle pulse).
- flit_out  out  DATAWID  registered accepted flit.
- valid_out  out  1  flit_out valid (1-cycle pulse per flit).
- grant  out  NREQ  registered one-hot owner while LOCKED, else 0.
- busy  out  1  1 while LOCKED.
- credit_cnt  out  CW  current credit count.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, prio pointer=0, credit_cnt=CREDITS.
  - flit_out=0, valid_out=0, grant=0, busy=0.
  - While rst is high, ready=0 and all req are ignored.
- Reset mid-packet: the lock is dropped without waiting for a tail; credits reload to CREDITS.
- Eligibility:
  - Accept is possible only when credit_cnt>0.
  - If credit_cnt==0, ready=0 regardless of req.
- IDLE:
  - Eligible requesters have req[i]=1 and flit_in[i][HEAD_BIT]=1.
  - A non-head flit presented in IDLE is ineligible and is held, never accepted or dropped.
  - Winner = first eligible index scanning prio, prio+1, …, wrapping modulo NREQ; ready[winner]=1.
  - On accept of head without tail: state→LOCKED, owner=winner, grant=onehot(owner), busy=1 (next cycle).
  - On accept of head with tail (single-flit packet): stay IDLE, prio←(winner+1) mod NREQ.
- LOCKED:
  - ready[owner]=req[owner]&(credit_cnt>0); all other ready bits are 0.
  - Owner bubbles (req low) are allowed; the lock holds indefinitely.
  - Owner flits are accepted regardless of HEAD_BIT (a head flit mid-packet is passed through unchanged).
  - On accept with TAIL_BIT=1: state→IDLE, grant=0, busy=0, prio←(owner+1) mod NREQ next cycle.
  - A new packet can be accepted in the cycle after the tail; there is no zero-gap arbitration on the tail cycle.
- Datapath:
  - On accept, the next cycle has flit_out=accepted flit and valid_out=1. Latency is 1 cycle.
  - With no accept, the next cycle has valid_out=0 and flit_out holds its last value.
- Credits:
  - Accept decrements credit_cnt.
  - credit_ret increments credit_cnt.
  - Accept and credit_ret in the same cycle leave credit_cnt unchanged.
  - credit_ret at credit_cnt==CREDITS saturates (no change).
  - An accept is never issued at 0, so there is no underflow.
- Throughput: 1 flit/cycle while credits are available.
- Fairness: no requester waits more than NREQ-1 packets.

Test Plan:
- Reset then single-flit packets: req=5'b11111, all flit_in with HEAD+TAIL set, credit_ret=1 every cycle → accept order 0,1,2,3,4,0; valid_out on 6 consecutive cycles each 1 cycle after accept; credit_cnt stays 4.
- Packet lock: req[1] sends head, 2 body, tail (4 flits) while req[3] holds a head → ready[3]=0 for all 4 cycles; grant=5'b00010, busy=1 during LOCKED; requester 3 accepted the cycle after the tail; then prio=2.
- Credit stall: no credit_ret; 6 single-flit packets from requester 0 → exactly 4 accepted, credit_cnt=0, ready=0; one credit_ret pulse → 5th accepted next cycle, credit_cnt back to 0.
- Simultaneous events: credit_cnt=2, accept and credit_ret in same cycle → credit_cnt=2; credit_ret pulse at credit_cnt=4 → stays 4.
- Non-head in IDLE: req[2]=1 with HEAD_BIT=0, others idle → ready=0, no valid_out for 10 cycles; req[4] head arrives → accepted.
- Reset mid-packet: owner=2 LOCKED with 2 flits sent, rst=1 one cycle → grant=0, busy=0, valid_out=0, credit_cnt=4, prio=0; next head from requester 3 (with 0 idle) accepted first cycle after reset.

Source files
------------

// File: rtl/xy_port_allocator.sv
// Round-robin, packet-locking allocator for one mesh-router output port.
// Holds the grant from head to tail, registers one flit per cycle and tracks downstream credits.
module xy_port_allocator #(
    parameter int NREQ     = 5,
    parameter int DATAWID  = 32,
    parameter int HEAD_BIT = 31,
    parameter int TAIL_BIT = 30,
    parameter int CREDITS  = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DATAWID-1:0] flit_in,
    output logic [NREQ-1:0]         ready,
    input  logic                    credit_ret,
    output logic [DATAWID-1:0]      flit_out,
    output logic                    valid_out,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [CW-1:0]           credit_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state, state_next;
    logic [IW-1:0]       prio, prio_next;
    logic [IW-1:0]       owner, owner_next;
    logic [IW-1:0]       winner;
    logic                win_found;
    logic [IW-1:0]       sel;
    logic                accept;
    logic [DATAWID-1:0]  sel_flit;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // Round-robin scan starting at prio; only head flits may open a packet.
    always_comb begin : scan
        int idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(prio) + k) % NREQ;
            if (!win_found && req[idx] && flit_in[idx*DATAWID + HEAD_BIT]) begin
                win_found = 1'b1;
                winner    = IW'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (!rst && credit_cnt != '0) begin
            if (state == LOCKED)
                ready[owner] = req[owner];
            else if (win_found)
                ready[winner] = 1'b1;
        end
    end

    assign sel      = (state == LOCKED) ? owner : winner;
    assign accept   = |(req & ready);
    assign sel_flit = flit_in[int'(sel)*DATAWID +: DATAWID];

    always_comb begin
        state_next = state;
        prio_next  = prio;
        owner_next = owner;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (sel_flit[TAIL_BIT]) begin
                        prio_next = wrap_inc(winner);
                    end else begin
                        state_next = LOCKED;
                        owner_next = winner;
                    end
                end
                LOCKED: begin
                    if (sel_flit[TAIL_BIT]) begin
                        state_next = IDLE;
                        prio_next  = wrap_inc(owner);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= '0;
            owner <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            prio  <= prio_next;
            owner <= owner_next;
            grant <= (state_next == LOCKED) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_next) : '0;
            busy  <= (state_next == LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_out   <= '0;
            valid_out  <= 1'b0;
            credit_cnt <= CW'(CREDITS);
        end else begin
            valid_out <= accept;
            if (accept)
                flit_out <= sel_flit;
            // A simultaneous accept and return cancel out; returns saturate at CREDITS.
            if (accept && !credit_ret)
                credit_cnt <= credit_cnt - CW'(1);
            else if (!accept && credit_ret && credit_cnt != CW'(CREDITS))
                credit_cnt <= credit_cnt + CW'(1);
        end
    end

endmodule
